// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register file widths, types and dump engine states
package regfile_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_NUM_REGS = 1 << RF_ADDR_W;
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;
  typedef enum logic [1:0] {DUMP_IDLE, DUMP_RUN, DUMP_DONE} dump_state_e;
endpackage

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: streams a wrapping register range from the debug read port as {addr, data} beats
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_first_addr,
  input  logic [ADDR_W-1:0] i_last_addr,
  output logic [ADDR_W-1:0] o_rf_addr,
  input  logic [DATA_W-1:0] i_rf_data,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [ADDR_W-1:0] o_dump_addr,
  output logic [DATA_W-1:0] o_dump_data,
  output logic              o_busy,
  output logic              o_done
);
  dump_state_e       state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W:0]   rem;
  logic [ADDR_W-1:0] span;
  logic              ld;
  logic              drained;
  assign span      = i_last_addr - i_first_addr;
  assign ld        = (!o_dump_valid || i_dump_ready) && rem != '0;
  assign drained   = !o_dump_valid || i_dump_ready;
  assign o_busy    = state != DUMP_IDLE;
  assign o_rf_addr = state == DUMP_RUN ? cur : '0;
  // Sequencer: walks cur over the range, loads the output register when it is free, pulses done once drained
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= DUMP_IDLE;
      cur          <= '0;
      rem          <= '0;
      o_dump_valid <= 1'b0;
      o_dump_addr  <= '0;
      o_dump_data  <= '0;
      o_done       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        DUMP_IDLE: begin
          if (i_start && !i_abort) begin
            cur   <= i_first_addr;
            rem   <= {1'b0, span} + 1'b1;
            state <= DUMP_RUN;
          end
        end
        DUMP_RUN: begin
          if (i_abort) begin
            o_dump_valid <= 1'b0;
            rem          <= '0;
            state        <= DUMP_IDLE;
          end else if (ld) begin
            o_dump_data  <= i_rf_data;
            o_dump_addr  <= cur;
            o_dump_valid <= 1'b1;
            cur          <= cur + 1'b1;
            rem          <= rem - 1'b1;
          end else if (drained) begin
            o_dump_valid <= 1'b0;
            o_done       <= 1'b1;
            state        <= DUMP_DONE;
          end
        end
        default: state <= DUMP_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed scoreboard bench for the regfile dump engine
module tb_regfile_dump_reader;
  import regfile_pkg::*;
  typedef logic [RF_ADDR_W+RF_DATA_W-1:0] beat_t;
  logic     i_clk = 1'b0;
  logic     i_rst = 1'b0;
  logic     i_start = 1'b0;
  logic     i_abort = 1'b0;
  rf_addr_t i_first_addr = '0;
  rf_addr_t i_last_addr = '0;
  rf_addr_t o_rf_addr;
  rf_data_t i_rf_data;
  logic     o_dump_valid;
  logic     i_dump_ready = 1'b1;
  rf_addr_t o_dump_addr;
  rf_data_t o_dump_data;
  logic     o_busy;
  logic     o_done;
  rf_data_t rf [RF_NUM_REGS];
  beat_t    exp_q [$];
  int       tests = 0;
  int       fails = 0;
  int       cyc, n_beats, n_done, first_cyc, last_cyc, done_cyc;
  regfile_dump_reader dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_first_addr(i_first_addr), .i_last_addr(i_last_addr), .o_rf_addr(o_rf_addr),
    .i_rf_data(i_rf_data), .o_dump_valid(o_dump_valid), .i_dump_ready(i_dump_ready),
    .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data), .o_busy(o_busy), .o_done(o_done)
  );
  assign i_rf_data = rf[o_rf_addr];
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    beat_t e;
    @(negedge i_clk);
    if (o_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (o_dump_valid && i_dump_ready) begin
      if (n_beats == 0) first_cyc = cyc;
      last_cyc = cyc;
      n_beats++;
      if (exp_q.size() == 0) chk("unexpected_beat", {o_dump_addr, o_dump_data}, '1);
      else begin
        e = exp_q.pop_front();
        chk("beat", {o_dump_addr, o_dump_data}, e);
      end
    end
    @(posedge i_clk);
    #1;
    cyc++;
  endtask
  task automatic start_dump(input rf_addr_t first, input rf_addr_t last);
    rf_addr_t a;
    int n;
    cyc = 0;
    n_beats = 0;
    n_done = 0;
    first_cyc = -1;
    last_cyc = -1;
    done_cyc = -1;
    exp_q.delete();
    n = int'(rf_addr_t'(last - first)) + 1;
    for (int i = 0; i < n; i++) begin
      a = first + rf_addr_t'(i);
      exp_q.push_back({a, rf[a]});
    end
    i_first_addr = first;
    i_last_addr = last;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask
  task automatic run_to_idle(input int max);
    int k = 0;
    while (o_busy && k < max) begin
      tick();
      k++;
    end
    chk("idle_timeout", o_busy, 0);
  endtask
  initial begin
    for (int i = 0; i < RF_NUM_REGS; i++) rf[i] = (i == 0) ? '0 : 32'h1000_0000 + i;
    #2;
    chk("rst_valid", o_dump_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_rf_addr", o_rf_addr, 0);
    chk("rst_beat", {o_dump_addr, o_dump_data}, 0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    // full 32-entry dump, ready high
    start_dump(5'd0, 5'd31);
    chk("full_c1_valid", o_dump_valid, 0);
    chk("full_c1_rf_addr", o_rf_addr, 0);
    while (cyc < 34) tick();
    chk("full_c34_done", o_done, 1);
    chk("full_c34_busy", o_busy, 1);
    tick();
    chk("full_c35_busy", o_busy, 0);
    chk("full_c35_done", o_done, 0);
    chk("full_first_cyc", first_cyc, 2);
    chk("full_last_cyc", last_cyc, 33);
    chk("full_beats", n_beats, 32);
    chk("full_done_cyc", done_cyc, 34);
    chk("full_q_empty", exp_q.size(), 0);
    // wrap through 31 -> 0
    start_dump(5'd30, 5'd1);
    run_to_idle(20);
    chk("wrap_beats", n_beats, 4);
    chk("wrap_dones", n_done, 1);
    chk("wrap_q_empty", exp_q.size(), 0);
    // backpressure on beat 5
    start_dump(5'd4, 5'd7);
    repeat (2) tick();
    i_dump_ready = 1'b0;
    repeat (3) begin
      chk("bp_valid", o_dump_valid, 1);
      chk("bp_addr", o_dump_addr, 5);
      chk("bp_data", o_dump_data, rf[5]);
      tick();
    end
    i_dump_ready = 1'b1;
    run_to_idle(20);
    chk("bp_beats", n_beats, 4);
    chk("bp_dones", n_done, 1);
    chk("bp_q_empty", exp_q.size(), 0);
    // single beat, second start while busy is ignored
    start_dump(5'd9, 5'd9);
    i_first_addr = 5'd0;
    i_last_addr = 5'd31;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    run_to_idle(20);
    repeat (3) tick();
    chk("single_beats", n_beats, 1);
    chk("single_dones", n_done, 1);
    chk("single_busy", o_busy, 0);
    chk("single_q_empty", exp_q.size(), 0);
    // abort while beat 3 is stalled
    start_dump(5'd0, 5'd31);
    repeat (4) tick();
    i_dump_ready = 1'b0;
    chk("abort_addr", o_dump_addr, 3);
    chk("abort_valid_pre", o_dump_valid, 1);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    i_dump_ready = 1'b1;
    chk("abort_valid", o_dump_valid, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_rf_addr", o_rf_addr, 0);
    repeat (4) tick();
    chk("abort_dones", n_done, 0);
    chk("abort_beats", n_beats, 3);
    chk("abort_q_left", exp_q.size(), 29);
    start_dump(5'd12, 5'd14);
    run_to_idle(20);
    chk("post_abort_beats", n_beats, 3);
    chk("post_abort_dones", n_done, 1);
    chk("post_abort_q_empty", exp_q.size(), 0);
    // asynchronous reset at beat 10
    start_dump(5'd0, 5'd31);
    repeat (11) tick();
    chk("rst_mid_addr", o_dump_addr, 10);
    i_rst = 1'b0;
    #1;
    chk("rst_mid_valid", o_dump_valid, 0);
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_rf_addr", o_rf_addr, 0);
    chk("rst_mid_beats", n_beats, 10);
    repeat (2) tick();
    i_rst = 1'b1;
    tick();
    chk("rst_mid_dones", n_done, 0);
    chk("rst_mid_q_left", exp_q.size(), 22);
    start_dump(5'd20, 5'd23);
    run_to_idle(20);
    chk("post_rst_beats", n_beats, 4);
    chk("post_rst_dones", n_done, 1);
    chk("post_rst_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug readout engine on the consumer side of the register file read port.
- On request, it sequences read addresses over a contiguous (wrapping) register range and samples the combinational read data.
- Each register value is streamed out as an {addr, data} beat on a valid/ready interface.
- Sits beside the core's regfile on a dedicated debug read port. Used by the test harness and debug bridge to snapshot architectural state.

Parameters:
- ADDR_W, 5, register address width; the register count is 2**ADDR_W.
- DATA_W, 32, register data width.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, asynchronous, active-low
- i_start  input  1  dump request; sampled only in IDLE
- i_abort  input  1  cancel the current dump
- i_first_addr  input  ADDR_W  first register of the range
- i_last_addr  input  ADDR_W  last register of the range (inclusive)
- o_rf_addr  output  ADDR_W  read address to the regfile debug port
- i_rf_data  input  DATA_W  combinational read data for o_rf_addr
- o_dump_valid  output  1  beat valid
- i_dump_ready  input  1  consumer ready
- o_dump_addr  output  ADDR_W  register index of the current beat
- o_dump_data  output  DATA_W  register value of the current beat
- o_busy  output  1  high in RUN and DONE
- o_done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset: state IDLE. All outputs are 0; the internal counter and remaining count are 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - o_rf_addr = 0, o_busy = 0.
  - i_start=1 with i_abort=0 → latch cur = i_first_addr and rem = ((i_last_addr - i_first_addr) mod 2**ADDR_W) + 1, then go to RUN.
  - rem is ADDR_W+1 bits, range 1..32.
- RUN:
  - o_rf_addr = cur.
  - Load condition: ld = (!o_dump_valid || i_dump_ready) && rem != 0.
  - On ld: o_dump_data <= i_rf_data, o_dump_addr <= cur, o_dump_valid <= 1, cur <= cur+1 (wraps 31→0), rem <= rem-1.
  - On !ld with o_dump_valid && i_dump_ready: o_dump_valid <= 0.
  - When rem == 0 and the output is empty or being accepted this cycle: clear valid and go to DONE.
- DONE: o_done = 1 for exactly one cycle, then IDLE.
- Throughput: 1 beat/cycle when i_dump_ready is held high.
- Latency: start accepted at edge N → first beat valid in cycle N+2.
- Full 32-entry dump with ready high: beats in cycles 2..33, o_done in cycle 34 (start sampled in cycle 0).
- Handshake rules:
  - While o_dump_valid=1 and i_dump_ready=0, o_dump_addr and o_dump_data hold stable.
  - No beat is dropped or duplicated.
- Wrap-around: first > last means the range wraps through 31→0. first == last means a single beat.
- Data coherence: each value is sampled at its load cycle. A concurrent regfile write is visible if it completes before that load cycle. No snapshot of the whole file is taken.
- i_start while busy: ignored.
- i_abort in RUN or DONE:
  - Next cycle: IDLE, o_dump_valid = 0, no o_done pulse.
  - A beat presented in the abort cycle with ready=1 counts as accepted.
- i_abort in IDLE: no effect. i_abort has priority over a simultaneous i_start.
- Reset mid-dump: immediate return to reset values. No done pulse.
- Reads of x0 return whatever the port returns (0); x0 is not skipped.

Decomposition:
- Shared package regfile_pkg:
  - RF_ADDR_W=5, RF_DATA_W=32, RF_NUM_REGS=32.
  - typedef rf_addr_t and rf_data_t.
  - enum dump_state_e {DUMP_IDLE, DUMP_RUN, DUMP_DONE}.
- Single module; no sub-module is needed. The counter and output register stay inline.

Test Plan:
- Full dump: regfile preloaded xN = 0x1000_0000+N, first=0, last=31, ready=1, start at cycle 0 → 32 beats addr 0..31 with matching data in cycles 2..33 (x0 = 0); o_done in cycle 34; o_busy low in cycle 35.
- Wrap: first=30, last=1 → exactly 4 beats, addr sequence 30, 31, 0, 1; one o_done.
- Backpressure: first=4, last=7; ready low for 3 cycles while beat addr 5 is valid → addr 5 and its data held constant; sequence 4, 5, 6, 7 with no gaps or repeats.
- Single/ignore: first=last=9 → one beat (addr 9); a second i_start pulsed during RUN is ignored, so exactly one o_done.
- Abort: full-range dump, i_abort asserted while beat addr 3 is valid with ready=0 → valid low next cycle, state IDLE, no o_done. A new start then runs normally.
- Reset mid-dump: i_rst low asynchronously at beat 10 → o_dump_valid, o_busy and o_rf_addr are 0 immediately. After release, a dump restarts cleanly.
